serial_subtractor_n: RTL

Bit-serial N-bit two's-complement subtractor computing `d = a - b`, one bit per clock, LSB first. It uses a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion of the ripple `adder_n` datapath: a small-area subtraction unit for the lab ALU, controlled by a start/busy/done handshake. Operands are captured on start, and results are held until the next accepted start.

---
 rtl/serial_subtractor_n_if.sv | 25 ++
 rtl/serial_subtractor_n.sv | 107 ++++++++++
 2 files changed

// File: rtl/serial_subtractor_n_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_n_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] d;
  logic         bout;
  logic         ovf;
  logic         busy;
  logic         done;

  // Requester side: issues start and operands, observes results.
  modport master (
    output start, a, b,
    input  d, bout, ovf, busy, done
  );

  // Subtractor side: consumes start and operands, produces results.
  modport slave (
    input  start, a, b,
    output d, bout, ovf, busy, done
  );
endinterface

// File: rtl/serial_subtractor_n.sv
// Bit-serial N-bit two's-complement subtractor (d = a - b), LSB first.
// One full-subtractor cell plus a borrow flop; start/busy/done handshake.
module serial_subtractor_n #(
  parameter int N = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_subtractor_n_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  ar;
  logic [N-1:0]  br;
  logic [N-1:0]  sr;
  logic [N-1:0]  d_q;
  logic          w;
  logic          bout_q;
  logic          ovf_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] cnt;

  logic x;
  logic y;
  logic diff;
  logic w_nxt;
  logic last;

  // Full-subtractor cell on the current LSBs and the running borrow.
  always_comb begin
    x     = ar[0];
    y     = br[0];
    diff  = x ^ y ^ w;
    w_nxt = (~x & y) | (~(x ^ y) & w);
    last  = (cnt == CW'(N - 1));
  end

  // Control FSM, operand shifters, result assembly and held outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ar     <= '0;
      br     <= '0;
      sr     <= '0;
      d_q    <= '0;
      w      <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            ar     <= bus.a;
            br     <= bus.b;
            w      <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          ar <= ar >> 1;
          br <= br >> 1;
          sr <= {diff, sr[N-1:1]};
          w  <= w_nxt;
          if (last) begin
            // On the MSB edge x/y are a[N-1]/b[N-1] and diff is d[N-1],
            // so overflow is derived here without keeping operand copies.
            d_q    <= {diff, sr[N-1:1]};
            bout_q <= w_nxt;
            ovf_q  <= (x ^ y) & (diff ^ x);
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
